pll_lock_supervisor: RTL and testbench

//  Controller on the consumer side of the PLL's RESET/LOCK interface. Drives the PLL's reset,

---
 rtl/pll_sup_pkg.sv | 18 +
 rtl/sync_2ff.sv | 23 ++
 rtl/pll_lock_supervisor.sv | 126 ++++++++++++
 tb/tb_pll_lock_supervisor.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and default 50 MHz timing for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        S_RST,
        S_WAIT,
        S_STAB,
        S_READY,
        S_FAIL
    } state_t;

    localparam int unsigned DEF_RST_CYCLES   = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT = 50000;
    localparam int unsigned DEF_LOCK_STABLE  = 1024;
    localparam int unsigned DEF_MAX_RETRY    = 3;
    localparam int unsigned DEF_CNT_W        = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with asynchronous active-high reset to zero.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives PLL reset, qualifies the synchronised lock, retries on timeout and
// publishes a registered clock-ready qualifier.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = DEF_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int unsigned LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int unsigned MAX_RETRY    = DEF_MAX_RETRY,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic                               clkin,
    input  logic                               reset,
    input  logic                               lock,
    input  logic                               restart,
    output logic                               pll_reset,
    output logic                               ready,
    output logic                               fail,
    output logic                               lock_lost,
    output logic [$clog2(MAX_RETRY+1)-1:0]     attempts
);

    localparam int unsigned AW = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [AW-1:0]    ATT_MAX   = AW'(MAX_RETRY);

    logic             lock_s;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk (clkin),
        .rst (reset),
        .d   (lock),
        .q   (lock_s)
    );

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state     <= S_RST;
            cnt       <= '0;
            attempts  <= '0;
            pll_reset <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
            lock_lost <= 1'b0;
        end else if (restart) begin
            state     <= S_RST;
            cnt       <= '0;
            attempts  <= '0;
            pll_reset <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            // Outputs are set on the edge that enters each state, so they
            // always reflect the state register without a decode stage.
            case (state)
                S_RST: begin
                    if (cnt == RST_LAST) begin
                        state     <= S_WAIT;
                        cnt       <= '0;
                        pll_reset <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (lock_s) begin
                        state <= S_STAB;
                        cnt   <= '0;
                    end else if (cnt == WAIT_LAST) begin
                        cnt       <= '0;
                        pll_reset <= 1'b1;
                        if (attempts == ATT_MAX) begin
                            state <= S_FAIL;
                            fail  <= 1'b1;
                        end else begin
                            state    <= S_RST;
                            attempts <= attempts + AW'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_STAB: begin
                    if (!lock_s) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end else if (cnt == STAB_LAST) begin
                        state <= S_READY;
                        cnt   <= '0;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_READY: begin
                    if (!lock_s) begin
                        state     <= S_RST;
                        cnt       <= '0;
                        attempts  <= '0;
                        pll_reset <= 1'b1;
                        ready     <= 1'b0;
                        lock_lost <= 1'b1;
                    end
                end
                S_FAIL: begin
                    pll_reset <= 1'b1;
                    ready     <= 1'b0;
                    fail      <= 1'b1;
                end
                default: begin
                    state     <= S_RST;
                    cnt       <= '0;
                    pll_reset <= 1'b1;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor with short timing parameters.
module tb_pll_lock_supervisor;

    localparam int T_RST = 4;
    localparam int T_TO  = 20;
    localparam int T_ST  = 8;
    localparam int T_MR  = 2;

    localparam int SEL_PLLR = 0;
    localparam int SEL_RDY  = 1;
    localparam int SEL_FAIL = 2;
    localparam int SEL_ATT  = 3;

    logic       clkin = 1'b0;
    logic       reset, lock, restart;
    logic       pll_reset, ready, fail, lock_lost;
    logic [1:0] attempts;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       pr;
        logic       rdy;
        logic       fl;
        logic       lost;
        logic [1:0] att;
    } exp_t;

    exp_t exp_q[$];

    typedef enum int {M_RST, M_WAIT, M_STAB, M_READY, M_FAIL} mst_t;
    mst_t m_state = M_RST;
    int   m_cnt   = 0;
    int   m_att   = 0;
    logic m_lost  = 1'b0;
    logic m_s1    = 1'b0;
    logic m_s2    = 1'b0;

    pll_lock_supervisor #(
        .RST_CYCLES   (T_RST),
        .LOCK_TIMEOUT (T_TO),
        .LOCK_STABLE  (T_ST),
        .MAX_RETRY    (T_MR),
        .CNT_W        (16)
    ) dut (
        .clkin     (clkin),
        .reset     (reset),
        .lock      (lock),
        .restart   (restart),
        .pll_reset (pll_reset),
        .ready     (ready),
        .fail      (fail),
        .lock_lost (lock_lost),
        .attempts  (attempts)
    );

    always #5 clkin = ~clkin;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: outputs derived from the modelled state after each edge.
    task automatic model_step();
        logic ls;
        mst_t nxt;
        int   age;
        exp_t e;
        if (reset) begin
            m_state = M_RST; m_cnt = 0; m_att = 0; m_lost = 1'b0;
            m_s1 = 1'b0; m_s2 = 1'b0;
        end else begin
            ls   = m_s2;
            m_s2 = m_s1;
            m_s1 = lock;
            if (restart) begin
                m_state = M_RST; m_cnt = 0; m_att = 0; m_lost = 1'b0;
            end else begin
                age = m_cnt + 1;
                nxt = m_state;
                case (m_state)
                    M_RST:   if (age == T_RST) nxt = M_WAIT;
                    M_WAIT:  if (ls) nxt = M_STAB;
                             else if (age == T_TO) begin
                                 if (m_att == T_MR) nxt = M_FAIL;
                                 else begin m_att++; nxt = M_RST; end
                             end
                    M_STAB:  if (!ls) nxt = M_WAIT;
                             else if (age == T_ST) nxt = M_READY;
                    M_READY: if (!ls) begin m_lost = 1'b1; m_att = 0; nxt = M_RST; end
                    default: ;
                endcase
                m_cnt   = (nxt != m_state) ? 0 : age;
                m_state = nxt;
            end
        end
        e.pr   = (m_state == M_RST) || (m_state == M_FAIL);
        e.rdy  = (m_state == M_READY);
        e.fl   = (m_state == M_FAIL);
        e.lost = m_lost;
        e.att  = 2'(m_att);
        exp_q.push_back(e);
    endtask

    always @(posedge clkin) model_step();

    always @(negedge clkin) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_pll_reset", pll_reset, e.pr);
            check("sb_ready", ready, e.rdy);
            check("sb_fail", fail, e.fl);
            check("sb_lock_lost", lock_lost, e.lost);
            check("sb_attempts", attempts, e.att);
        end
    end

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            SEL_PLLR: return pll_reset;
            SEL_RDY:  return ready;
            SEL_FAIL: return fail;
            default:  return attempts != 2'd0;
        endcase
    endfunction

    // Edges until the selected output reaches val; -1 if the budget expires.
    task automatic wait_for(input int sel, input logic val, input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            tick();
            if (sig(sel) === val) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic assert_reset();
        @(negedge clkin);
        #1;
        reset = 1'b1;
        #1;
    endtask

    task automatic release_reset();
        @(posedge clkin);
        @(negedge clkin);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; lock = 1'b0; restart = 1'b0;
        repeat (3) @(posedge clkin);
        #1;
        check("rst_pll_reset", pll_reset, 1);
        check("rst_ready", ready, 0);
        check("rst_fail", fail, 0);
        check("rst_lock_lost", lock_lost, 0);
        check("rst_attempts", attempts, 0);
        release_reset();

        // Initial qualification
        wait_for(SEL_PLLR, 1'b0, 50, n);
        check("t1_rst_len", n, T_RST);
        repeat (9) tick();
        lock = 1'b1;
        wait_for(SEL_RDY, 1'b1, 50, n);
        check("t1_ready_edge", n, T_ST + 3);
        check("t1_fail", fail, 0);
        check("t1_attempts", attempts, 0);

        // Loss of lock while ready
        repeat (3) tick();
        lock = 1'b0;
        wait_for(SEL_RDY, 1'b0, 10, n);
        check("t4_ready_fall", n, 3);
        check("t4_lock_lost", lock_lost, 1);
        check("t4_pll_reset", pll_reset, 1);
        wait_for(SEL_PLLR, 1'b0, 20, n);
        check("t4_rst_len", n, T_RST);
        lock = 1'b1;
        wait_for(SEL_RDY, 1'b1, 50, n);
        check("t4_requal", n, T_ST + 3);
        check("t4_lost_sticky", lock_lost, 1);

        // Asynchronous reset while ready
        assert_reset();
        check("t6r_pll_reset", pll_reset, 1);
        check("t6r_ready", ready, 0);
        check("t6r_lock_lost", lock_lost, 0);
        lock = 1'b0;
        release_reset();

        // One timeout, then a lock glitch during stabilisation
        wait_for(SEL_ATT, 1'b1, 100, n);
        check("t3_first_timeout", n, T_RST + T_TO);
        wait_for(SEL_PLLR, 1'b0, 20, n);
        check("t3_rst_len", n, T_RST);
        lock = 1'b1;
        repeat (7) tick();
        check("t3_no_early_ready", ready, 0);
        lock = 1'b0;
        tick();
        lock = 1'b1;
        wait_for(SEL_RDY, 1'b1, 50, n);
        check("t3_ready_after_glitch", n, T_ST + 3);
        check("t3_attempts", attempts, 1);

        // Restart from ready, then asynchronous reset while stabilising
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("rs_ready", ready, 0);
        check("rs_attempts", attempts, 0);
        wait_for(SEL_PLLR, 1'b0, 20, n);
        check("rs_rst_len", n, T_RST);
        repeat (3) tick();
        assert_reset();
        check("t6s_pll_reset", pll_reset, 1);
        check("t6s_ready", ready, 0);
        release_reset();
        wait_for(SEL_PLLR, 1'b0, 20, n);
        check("t6s_rst_len", n, T_RST);
        wait_for(SEL_RDY, 1'b1, 50, n);
        check("t6s_ready_edge", n, T_ST + 1);
        check("t6s_attempts", attempts, 0);

        // Exhaust all attempts
        assert_reset();
        lock = 1'b0;
        release_reset();
        wait_for(SEL_FAIL, 1'b1, 200, n);
        check("t2_fail_edge", n, (T_MR + 1) * (T_RST + T_TO));
        check("t2_attempts", attempts, T_MR);
        check("t2_pll_reset", pll_reset, 1);
        repeat (5) tick();
        check("t2_fail_held", fail, 1);

        // Restart out of fail with lock present
        lock = 1'b1;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("t5_fail", fail, 0);
        check("t5_attempts", attempts, 0);
        check("t5_lock_lost", lock_lost, 0);
        check("t5_pll_reset", pll_reset, 1);
        wait_for(SEL_PLLR, 1'b0, 20, n);
        check("t5_rst_len", n, T_RST);
        wait_for(SEL_RDY, 1'b1, 50, n);
        check("t5_ready_edge", n, T_ST + 1);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
